// File: rtl/rv_wb_pkg.sv
// Shared types for the Wishbone arbiter: FSM state, grant owner and fetch byte select.
package rv_wb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_INSTR = 2'd1,
        GNT_DATA  = 2'd2
    } arb_grant_t;

    localparam logic [3:0] FETCH_SEL = 4'hF;

endpackage

// File: rtl/rv_wb_timeout.sv
// Bus-cycle watchdog: counts while enabled, flags expiry on the last allowed cycle.
module rv_wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_tie;
            assign unused_tie = ^{i_clk, i_reset_n, i_clr, i_en};
            assign o_expired  = 1'b0;
        end else begin : g_on
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (i_clr) begin
                    cnt_d = '0;
                end else if (i_en) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Expiry is flagged during the final cycle so the abort lands on the same edge.
            assign o_expired = i_en && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/rv_wb_arbiter.sv
// Shares one Wishbone classic master between instruction fetch and load/store,
// one transfer at a time, data-first with a burst limit protecting pending fetches.
module rv_wb_arbiter #(
    parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
    parameter int unsigned IADDR_SPACE_BITS = 16,
    parameter int unsigned DATA_BURST_MAX   = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_instr_req,
    input  logic [IADDR_SPACE_BITS-1:1]   i_instr_addr,
    output logic                          o_instr_ack,
    output logic                          o_instr_err,
    output logic [31:0]                   o_instr_data,
    input  logic                          i_data_req,
    input  logic                          i_data_write,
    input  logic [31:0]                   i_data_addr,
    input  logic [31:0]                   i_data_wdata,
    input  logic [3:0]                    i_data_sel,
    output logic                          o_data_ack,
    output logic                          o_data_err,
    output logic [31:0]                   o_data_rdata,
    output logic                          o_wb_cyc,
    output logic                          o_wb_stb,
    output logic [31:0]                   o_wb_adr,
    output logic [31:0]                   o_wb_dat,
    output logic                          o_wb_we,
    output logic [3:0]                    o_wb_sel,
    input  logic [31:0]                   i_wb_dat,
    input  logic                          i_wb_ack,
    input  logic                          i_wb_err
);

    import rv_wb_pkg::*;

    arb_state_t  state_q, state_d;
    arb_grant_t  grant_q, grant_d;
    logic [3:0]  burst_q, burst_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        tmo_expired;
    logic        fetch_wins;
    logic [31:0] fetch_adr;

    assign fetch_adr  = {RESET_ADDR[31:IADDR_SPACE_BITS], i_instr_addr, 1'b0};
    // Fetch only overtakes data once the data port has used up its burst allowance.
    assign fetch_wins = i_instr_req && (!i_data_req || (burst_q == 4'(DATA_BURST_MAX)));

    rv_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (state_q == ARB_RESP),
        .i_en      (state_q == ARB_BUS),
        .o_expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (fetch_wins) begin
                    state_d = ARB_BUS;
                    grant_d = GNT_INSTR;
                    cyc_d   = 1'b1;
                    adr_d   = fetch_adr;
                    dat_d   = i_data_wdata;
                    we_d    = 1'b0;
                    sel_d   = FETCH_SEL;
                    burst_d = '0;
                end else if (i_data_req) begin
                    state_d = ARB_BUS;
                    grant_d = GNT_DATA;
                    cyc_d   = 1'b1;
                    adr_d   = i_data_addr;
                    dat_d   = i_data_wdata;
                    we_d    = i_data_write;
                    sel_d   = i_data_sel;
                    if (!i_instr_req) begin
                        burst_d = '0;
                    end else if (burst_q != 4'hF) begin
                        burst_d = burst_q + 4'd1;
                    end
                end
            end
            ARB_BUS: begin
                if (i_wb_ack) begin
                    state_d = ARB_RESP;
                    cyc_d   = 1'b0;
                    ok_d    = 1'b1;
                    rdata_d = i_wb_dat;
                end else if (i_wb_err || tmo_expired) begin
                    state_d = ARB_RESP;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                grant_d = GNT_NONE;
                rdata_d = '0;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = GNT_NONE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= GNT_NONE;
            burst_q <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Response flags live only in RESP, so gating by grant routes them to one port.
    assign o_instr_ack  = ok_q  && (grant_q == GNT_INSTR);
    assign o_instr_err  = err_q && (grant_q == GNT_INSTR);
    assign o_data_ack   = ok_q  && (grant_q == GNT_DATA);
    assign o_data_err   = err_q && (grant_q == GNT_DATA);
    assign o_instr_data = o_instr_ack ? rdata_q : 32'h0;
    assign o_data_rdata = o_data_ack  ? rdata_q : 32'h0;

    assign o_wb_cyc = cyc_q;
    assign o_wb_stb = cyc_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_we  = we_q;
    assign o_wb_sel = sel_q;

endmodule
